// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: flag bit positions,
// occupancy encodings and unit_A function codes.
package alu_result_stage_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam logic [1:0] FN_ADD  = 2'b00;
    localparam logic [1:0] FN_SUB  = 2'b01;
    localparam logic [1:0] FN_ADDC = 2'b10;
    localparam logic [1:0] FN_SUBB = 2'b11;

endpackage

// File: rtl/alu_result_stage_skid_buf.sv
// Generic 2-entry valid/ready buffer. in_ready decodes registered state only,
// so there is no combinational path from out_ready back to in_ready.
module skid_buf
    import alu_result_stage_pkg::*;
#(
    parameter int PAYLOAD_W = 38
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    occ_e                 state;
    occ_e                 state_nxt;
    logic                 accept;
    logic                 pop;
    logic [PAYLOAD_W-1:0] slot_p0;
    logic [PAYLOAD_W-1:0] slot_p1;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            OCC_EMPTY: if (accept) state_nxt = OCC_ONE;
            OCC_ONE: begin
                if (accept && !pop)      state_nxt = OCC_FULL;
                else if (pop && !accept) state_nxt = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) state_nxt = OCC_ONE;
            default:   state_nxt = OCC_EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (state != OCC_FULL);
        out_valid = (state != OCC_EMPTY);
    end

    // slot_p0 is always the oldest entry; slot_p1 only holds data while FULL
    always_ff @(posedge clk) begin
        unique case (state)
            OCC_EMPTY: if (accept) slot_p0 <= in_data;
            OCC_ONE: begin
                if (accept && pop) slot_p0 <= in_data;
                else if (accept)   slot_p1 <= in_data;
            end
            OCC_FULL:  if (pop) slot_p0 <= slot_p1;
            default: ;
        endcase
    end

    // Storage is not reset; an empty buffer presents zeros instead.
    assign out_data = out_valid ? slot_p0 : '0;

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind unit_A: derives N/Z/C/V, buffers results in a
// 2-entry skid buffer and keeps a sticky overflow flag. ALU_OVF_COUNT_EN adds ovf_count.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH = 32
`ifdef ALU_OVF_COUNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_c,
    input  logic             in_o,
    input  logic [1:0]       in_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic [3:0]       out_flags,
    output logic [1:0]       out_f,
    input  logic             clr_sticky,
    output logic             sticky_v
`ifdef ALU_OVF_COUNT_EN
    ,
    output logic [CNT_W-1:0] ovf_count
`endif
);

    localparam int PAYLOAD_W = WIDTH + 6;

    logic [3:0]           flags_p0;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 ovf_evt;

    always_comb begin
        flags_p0         = '0;
        flags_p0[FLAG_N] = in_s[WIDTH-1];
        flags_p0[FLAG_Z] = (in_s == '0);
        flags_p0[FLAG_C] = in_c;
        flags_p0[FLAG_V] = in_o;
    end

    assign in_payload = {in_f, flags_p0, in_s};

    skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {out_f, out_flags, out_s} = out_payload;

    // ---- stage p1: overflow bookkeeping on accepted results ----
    assign ovf_evt = in_valid && in_ready && in_o;

    // A new overflow outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v <= 1'b0;
        end else if (ovf_evt) begin
            sticky_v <= 1'b1;
        end else if (clr_sticky) begin
            sticky_v <= 1'b0;
        end
    end

`ifdef ALU_OVF_COUNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (clr_sticky) begin
            ovf_count <= ovf_evt ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (ovf_evt) begin
            ovf_count <= sat_inc(ovf_count);
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: queue-based reference model checked
// every cycle, plus directed literal checks. Covers ALU_OVF_COUNT_EN when defined.
module tb_alu_result_stage;

    localparam int WIDTH = 32;
`ifdef ALU_OVF_COUNT_EN
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_s;
    logic             in_c;
    logic             in_o;
    logic [1:0]       in_f;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic [3:0]       out_flags;
    logic [1:0]       out_f;
    logic             clr_sticky;
    logic             sticky_v;
`ifdef ALU_OVF_COUNT_EN
    logic [CNT_W-1:0] ovf_count;
`endif

    alu_result_stage #(
        .WIDTH (WIDTH)
`ifdef ALU_OVF_COUNT_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .in_c       (in_c),
        .in_o       (in_o),
        .in_f       (in_f),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_flags  (out_flags),
        .out_f      (out_f),
        .clr_sticky (clr_sticky),
        .sticky_v   (sticky_v)
`ifdef ALU_OVF_COUNT_EN
        ,
        .ovf_count  (ovf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic [3:0]  flags;
        logic [1:0]  f;
    } ent_t;

    ent_t q[$];
    logic m_sticky;
    int   m_cnt;
    int   total;
    int   bad;

    initial begin
        total = 0;
        bad   = 0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a FIFO of at most two results, flags from the raw inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_sticky <= 1'b0;
            m_cnt    <= 0;
        end else begin
            automatic bit   acc = in_valid && (q.size() < 2);
            automatic bit   pp  = (q.size() != 0) && out_ready;
            automatic ent_t e;
            e.s     = in_s;
            e.flags = {in_s[31], (in_s == 32'h0), in_c, in_o};
            e.f     = in_f;
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (acc && in_o) m_sticky <= 1'b1;
            else if (clr_sticky) m_sticky <= 1'b0;
`ifdef ALU_OVF_COUNT_EN
            if (clr_sticky) m_cnt <= (acc && in_o) ? 1 : 0;
            else if (acc && in_o && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
`endif
        end
    end

    always @(negedge clk) begin
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        check("sticky_v", 64'(sticky_v), 64'(m_sticky));
`ifdef ALU_OVF_COUNT_EN
        check("ovf_count", 64'(ovf_count), 64'(m_cnt));
`endif
        if (q.size() != 0) begin
            check("out_s", 64'(out_s), 64'(q[0].s));
            check("out_flags", 64'(out_flags), 64'(q[0].flags));
            check("out_f", 64'(out_f), 64'(q[0].f));
        end
    end

    task automatic set_in(input logic v, input logic [31:0] s, input logic c,
                          input logic o, input logic [1:0] f);
        in_valid = v;
        in_s     = s;
        in_c     = c;
        in_o     = o;
        in_f     = f;
    endtask

    logic [31:0] vs [6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001,
                            32'h12345678, 32'h00000000, 32'h80000001};
    logic        vc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        vo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  vf [6] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd3};

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_s", 64'(out_s), 64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        check("rst_out_f", 64'(out_f), 64'd0);
        check("rst_sticky", 64'(sticky_v), 64'd0);
        rst_n = 1'b1;

        // negative overflow result
        @(negedge clk);
        out_ready = 1'b1;
        set_in(1'b1, 32'h80000000, 1'b0, 1'b1, 2'b00);
        @(negedge clk);
        check("t1_flags", 64'(out_flags), 64'h9);
        check("t1_sticky", 64'(sticky_v), 64'd1);
        check("t1_out_s", 64'(out_s), 64'h80000000);
`ifdef ALU_OVF_COUNT_EN
        check("t1_count", 64'(ovf_count), 64'd1);
`endif
        // zero result with carry
        set_in(1'b1, 32'h0, 1'b1, 1'b0, 2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_flags", 64'(out_flags), 64'h6);
        check("t2_out_f", 64'(out_f), 64'd1);
        check("t2_sticky", 64'(sticky_v), 64'd1);
        @(negedge clk);

        // full-rate streaming
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, vs[i], vc[i], vo[i], vf[i]);
            @(negedge clk);
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_drained", 64'(out_valid), 64'd0);

        // backpressure with A, B, C
        out_ready = 1'b0;
        set_in(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        set_in(1'b1, 32'h11111111, 1'b1, 1'b0, 2'd1);
        @(negedge clk);
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        check("bp_head_a", 64'(out_s), 64'hA5A5A5A5);
        set_in(1'b1, 32'h0000C0DE, 1'b0, 1'b1, 2'd2);
        repeat (2) begin
            @(negedge clk);
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold_a", 64'(out_s), 64'hA5A5A5A5);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_pop_b", 64'(out_s), 64'h11111111);
        check("bp_ready_again", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_pop_c", 64'(out_s), 64'h0000C0DE);
        check("bp_c_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("bp_empty", 64'(out_valid), 64'd0);

        // stall stability with one entry
        out_ready = 1'b0;
        set_in(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 2'd2);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stall_s", 64'(out_s), 64'hDEADBEEF);
            check("stall_flags", 64'(out_flags), 64'hA);
            check("stall_f", 64'(out_f), 64'd2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);

        // sticky clear, then clear racing a new overflow
        clr_sticky = 1'b1;
        @(negedge clk);
        check("clr_sticky", 64'(sticky_v), 64'd0);
        set_in(1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        clr_sticky = 1'b0;
        in_valid   = 1'b0;
        check("clr_set_sticky", 64'(sticky_v), 64'd1);
`ifdef ALU_OVF_COUNT_EN
        check("clr_set_count", 64'(ovf_count), 64'd1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h100 + 32'(i), 1'b0, 1'b1, 2'd1);
            @(negedge clk);
        end
        check("sat_count", 64'(ovf_count), 64'd3);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        in_valid   = 1'b0;
        check("sat_clr_count", 64'(ovf_count), 64'd1);
        check("sat_clr_sticky", 64'(sticky_v), 64'd1);
`endif
        @(negedge clk);

        // async reset while FULL
        out_ready = 1'b0;
        set_in(1'b1, 32'h00000042, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        set_in(1'b1, 32'h00000043, 1'b0, 1'b1, 2'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_full", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        check("mid_rst_sticky", 64'(sticky_v), 64'd0);
        check("mid_rst_out_s", 64'(out_s), 64'd0);
`ifdef ALU_OVF_COUNT_EN
        check("mid_rst_count", 64'(ovf_count), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 32'h0BADF00D, 1'b0, 1'b0, 2'd3);
        @(negedge clk);
        in_valid = 1'b0;
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_ready", 64'(in_ready), 64'd1);
        check("post_rst_s", 64'(out_s), 64'h0BADF00D);
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_empty", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
